// File: rtl/spi_rx_packer.sv
// spi_rx_packer: packs 8/16/24/32-bit SPI receive frames into dense
// little-endian 32-bit FIFO words. A frame flagged last forces out any
// partially filled word together with its valid-byte count.
//
// Handshakes (both sides): a transfer happens on a rising clk edge where
// valid and ready are both high. Valid, once raised, holds its payload
// stable until ready is seen; ready may depend combinationally on the
// consumer's ready (frm_ready_o follows word_ready_i in the same cycle).
module spi_rx_packer #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  en_i,
  input  logic [1:0]            rdtb_i,
  input  logic                  frm_valid_i,
  output logic                  frm_ready_o,
  input  logic [DATA_WIDTH-1:0] frm_data_i,
  input  logic                  frm_last_i,
  output logic                  word_valid_o,
  input  logic                  word_ready_i,
  output logic [DATA_WIDTH-1:0] word_data_o,
  output logic [2:0]            word_bcnt_o,
  output logic [1:0]            fill_o,
  output logic                  busy_o
);

  // ACC: accepting frames; FLUSH: draining the leftover bytes of a last frame
  typedef enum logic {
    ST_ACC   = 1'b0,
    ST_FLUSH = 1'b1
  } state_e;

  state_e                  state_q, state_d;
  logic [1:0]              fill_q, fill_d;
  logic [23:0]             stage_q, stage_d;
  logic                    word_valid_q, word_valid_d;
  logic [DATA_WIDTH-1:0]   word_data_q, word_data_d;
  logic [2:0]              word_bcnt_q, word_bcnt_d;

  logic                    slot_free;
  logic                    accept;
  logic [2:0]              total;
  logic [DATA_WIDTH-1:0]   frm_mask;
  logic [55:0]             combined;
  logic                    emit;
  logic [DATA_WIDTH-1:0]   emit_data;
  logic [2:0]              emit_bcnt;

  // Output slot can take a new word when empty or being drained this cycle
  assign slot_free   = ~word_valid_q | word_ready_i;
  assign frm_ready_o = ~rst_i & en_i & (state_q == ST_ACC) & slot_free;
  assign accept      = frm_valid_i & frm_ready_o;
  assign total       = {1'b0, fill_q} + {1'b0, rdtb_i} + 3'd1;

  // Keep only the bytes of the current frame size
  always_comb begin
    frm_mask = '0;
    case (rdtb_i)
      2'd0:    frm_mask = 32'h0000_00FF;
      2'd1:    frm_mask = 32'h0000_FFFF;
      2'd2:    frm_mask = 32'h00FF_FFFF;
      default: frm_mask = 32'hFFFF_FFFF;
    endcase
  end

  // Lanes 0..fill-1 from staging, frame bytes placed directly above them.
  // Staging lanes at or above fill are always zero, so a plain OR merges.
  assign combined = ({24'd0, frm_data_i & frm_mask} << {fill_q, 3'b000})
                  | {32'd0, stage_q};

  // Next-state and output-slot computation
  always_comb begin
    state_d      = state_q;
    fill_d       = fill_q;
    stage_d      = stage_q;
    word_valid_d = word_valid_q;
    word_data_d  = word_data_q;
    word_bcnt_d  = word_bcnt_q;
    emit         = 1'b0;
    emit_data    = '0;
    emit_bcnt    = 3'd0;

    if (!en_i) begin
      // Synchronous flush: identical to reset
      state_d      = ST_ACC;
      fill_d       = 2'd0;
      stage_d      = 24'd0;
      word_valid_d = 1'b0;
      word_data_d  = '0;
      word_bcnt_d  = 3'd0;
    end else begin
      if (state_q == ST_ACC) begin
        if (accept) begin
          if (total < 3'd4) begin
            if (frm_last_i) begin
              emit      = 1'b1;
              emit_data = combined[31:0];
              emit_bcnt = total;
              fill_d    = 2'd0;
              stage_d   = 24'd0;
            end else begin
              stage_d = combined[23:0];
              fill_d  = total[1:0];
            end
          end else begin
            // A full word always goes out; leftover lanes (if any) move down
            emit      = 1'b1;
            emit_data = combined[31:0];
            emit_bcnt = 3'd4;
            stage_d   = combined[55:32];
            fill_d    = total[1:0];
            if (frm_last_i && (total != 3'd4)) begin
              state_d = ST_FLUSH;
            end
          end
        end
      end else begin
        // FLUSH: leftover staging becomes a partial word once the slot frees
        if (slot_free) begin
          emit      = 1'b1;
          emit_data = {8'd0, stage_q};
          emit_bcnt = {1'b0, fill_q};
          fill_d    = 2'd0;
          stage_d   = 24'd0;
          state_d   = ST_ACC;
        end
      end

      if (emit) begin
        word_valid_d = 1'b1;
        word_data_d  = emit_data;
        word_bcnt_d  = emit_bcnt;
      end else if (word_ready_i) begin
        word_valid_d = 1'b0;
        word_data_d  = '0;
        word_bcnt_d  = 3'd0;
      end
    end
  end

  // State and registered outputs
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= ST_ACC;
      fill_q       <= 2'd0;
      stage_q      <= 24'd0;
      word_valid_q <= 1'b0;
      word_data_q  <= '0;
      word_bcnt_q  <= 3'd0;
    end else begin
      state_q      <= state_d;
      fill_q       <= fill_d;
      stage_q      <= stage_d;
      word_valid_q <= word_valid_d;
      word_data_q  <= word_data_d;
      word_bcnt_q  <= word_bcnt_d;
    end
  end

  assign word_valid_o = word_valid_q;
  assign word_data_o  = word_data_q;
  assign word_bcnt_o  = word_bcnt_q;
  assign fill_o       = fill_q;
  assign busy_o       = (fill_q != 2'd0) | (state_q == ST_FLUSH) | word_valid_q;

endmodule

// File: tb/tb_spi_rx_packer.sv
// Testbench for spi_rx_packer: directed scenarios with literal expectations
// plus randomized frames, all checked every cycle against a byte-queue model.
module tb_spi_rx_packer;

  // ---------------- clock / reset ----------------
  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        en_i = 1'b1;
  logic [1:0]  rdtb_i = 2'd0;
  logic        frm_valid_i = 1'b0;
  logic        frm_ready_o;
  logic [31:0] frm_data_i = 32'd0;
  logic        frm_last_i = 1'b0;
  logic        word_valid_o;
  logic        word_ready_i = 1'b1;
  logic [31:0] word_data_o;
  logic [2:0]  word_bcnt_o;
  logic [1:0]  fill_o;
  logic        busy_o;

  always #5 clk_i = ~clk_i;

  spi_rx_packer #(.DATA_WIDTH(32)) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .en_i         (en_i),
    .rdtb_i       (rdtb_i),
    .frm_valid_i  (frm_valid_i),
    .frm_ready_o  (frm_ready_o),
    .frm_data_i   (frm_data_i),
    .frm_last_i   (frm_last_i),
    .word_valid_o (word_valid_o),
    .word_ready_i (word_ready_i),
    .word_data_o  (word_data_o),
    .word_bcnt_o  (word_bcnt_o),
    .fill_o       (fill_o),
    .busy_o       (busy_o)
  );

  int checks   = 0;
  int failures = 0;
  int timeouts = 0;
  bit sim_done = 1'b0;
  bit rdy_rand = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model / scoreboard ----------------
  // byte_q : received bytes not yet part of any word
  // exp_q  : {bcnt,data} words already formed but waiting for the output slot
  // m_valid/m_word : what the output slot must show this cycle
  logic [7:0]  byte_q[$];
  logic [34:0] exp_q[$];
  logic        m_valid = 1'b0;
  logic [34:0] m_word = 35'd0;
  logic        m_slot_free, m_exp_ready, m_exp_busy, m_emit;
  logic [34:0] m_nw, m_pw;
  logic [31:0] m_wd;
  int          m_fill, m_nb;

  // Compare DUT to the model, then advance the model by one clock
  always @(negedge clk_i) begin
    if (!sim_done) begin
      if (rst_i) begin
        byte_q.delete();
        exp_q.delete();
        m_valid = 1'b0;
        chk("rst_valid", {31'd0, word_valid_o}, 32'd0);
        chk("rst_ready", {31'd0, frm_ready_o}, 32'd0);
        chk("rst_fill",  {30'd0, fill_o}, 32'd0);
        chk("rst_busy",  {31'd0, busy_o}, 32'd0);
      end else begin
        m_slot_free = !m_valid || word_ready_i;
        m_exp_ready = en_i && (exp_q.size() == 0) && m_slot_free;
        m_fill = byte_q.size();
        if (exp_q.size() != 0) m_fill += int'(exp_q[0][34:32]);
        m_exp_busy = (m_fill != 0) || (exp_q.size() != 0) || m_valid;

        chk("frm_ready", {31'd0, frm_ready_o}, {31'd0, m_exp_ready});
        chk("word_valid", {31'd0, word_valid_o}, {31'd0, m_valid});
        chk("fill", {30'd0, fill_o}, 32'(m_fill));
        chk("busy", {31'd0, busy_o}, {31'd0, m_exp_busy});
        if (m_valid) begin
          chk("word_data", word_data_o, m_word[31:0]);
          chk("word_bcnt", {29'd0, word_bcnt_o}, {29'd0, m_word[34:32]});
        end

        m_emit = 1'b0;
        m_nw = 35'd0;
        if (!en_i) begin
          byte_q.delete();
          exp_q.delete();
          m_valid = 1'b0;
        end else begin
          if (exp_q.size() != 0) begin
            if (m_slot_free) begin
              m_nw = exp_q.pop_front();
              m_emit = 1'b1;
            end
          end else if (frm_valid_i && m_exp_ready) begin
            for (int k = 0; k <= int'(rdtb_i); k++) byte_q.push_back(frm_data_i[8*k +: 8]);
            if (byte_q.size() >= 4) begin
              m_wd = 32'd0;
              for (int i = 0; i < 4; i++) m_wd[8*i +: 8] = byte_q.pop_front();
              m_nw = {3'd4, m_wd};
              m_emit = 1'b1;
            end
            if (frm_last_i && byte_q.size() != 0) begin
              m_nb = byte_q.size();
              m_wd = 32'd0;
              for (int i = 0; i < m_nb; i++) m_wd[8*i +: 8] = byte_q.pop_front();
              m_pw = {3'(m_nb), m_wd};
              if (m_emit) exp_q.push_back(m_pw);
              else begin
                m_nw = m_pw;
                m_emit = 1'b1;
              end
            end
          end
          if (m_emit) begin
            m_valid = 1'b1;
            m_word = m_nw;
          end else if (word_ready_i) begin
            m_valid = 1'b0;
          end
        end
      end
    end
  end

  // Random consumer backpressure when enabled
  initial begin
    forever begin
      @(posedge clk_i);
      #1;
      if (rdy_rand) word_ready_i = ($urandom_range(0, 3) != 0);
    end
  end

  // ---------------- driver tasks ----------------
  // Offer one frame and hold it until accepted; returns 1 time unit after the accepting edge
  task automatic send_frame(input logic [1:0] sz, input logic [31:0] d, input logic last);
    bit acc;
    acc = 1'b0;
    rdtb_i = sz;
    frm_data_i = d;
    frm_last_i = last;
    frm_valid_i = 1'b1;
    for (int t = 0; t < 200; t++) begin
      @(negedge clk_i);
      if (frm_ready_o) begin
        acc = 1'b1;
        break;
      end
    end
    @(posedge clk_i);
    #1;
    frm_valid_i = 1'b0;
    frm_last_i = 1'b0;
    if (!acc) begin
      timeouts++;
      chk("frame_accept_timeout", 32'd0, 32'd1);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk_i);
      #1;
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    // reset values, with en_i high while reset is held
    idle(2);
    chk("reset_valid", {31'd0, word_valid_o}, 32'd0);
    chk("reset_data", word_data_o, 32'd0);
    chk("reset_bcnt", {29'd0, word_bcnt_o}, 32'd0);
    chk("reset_fill", {30'd0, fill_o}, 32'd0);
    chk("reset_ready", {31'd0, frm_ready_o}, 32'd0);
    chk("reset_busy", {31'd0, busy_o}, 32'd0);
    rst_i = 1'b0;
    idle(1);

    // four bytes -> one dense word, valid exactly the cycle after the 4th accept
    send_frame(2'd0, 32'h11, 1'b0);
    send_frame(2'd0, 32'h22, 1'b0);
    send_frame(2'd0, 32'h33, 1'b0);
    chk("t1_no_early_valid", {31'd0, word_valid_o}, 32'd0);
    chk("t1_fill3", {30'd0, fill_o}, 32'd3);
    send_frame(2'd0, 32'h44, 1'b0);
    chk("t1_valid", {31'd0, word_valid_o}, 32'd1);
    chk("t1_data", word_data_o, 32'h44332211);
    chk("t1_bcnt", {29'd0, word_bcnt_o}, 32'd4);
    chk("t1_fill0", {30'd0, fill_o}, 32'd0);
    chk("t1_model", m_word[31:0], 32'h44332211);
    idle(1);

    // 24-bit frames with last spilling into a flush word
    send_frame(2'd2, 32'h00AABBCC, 1'b0);
    send_frame(2'd2, 32'h00112233, 1'b1);
    chk("t2_w0_data", word_data_o, 32'h33AABBCC);
    chk("t2_w0_bcnt", {29'd0, word_bcnt_o}, 32'd4);
    chk("t2_flush_ready", {31'd0, frm_ready_o}, 32'd0);
    idle(1);
    chk("t2_w1_valid", {31'd0, word_valid_o}, 32'd1);
    chk("t2_w1_data", word_data_o, 32'h00001122);
    chk("t2_w1_bcnt", {29'd0, word_bcnt_o}, 32'd2);
    chk("t2_model", m_word[31:0], 32'h00001122);
    idle(1);
    chk("t2_busy_done", {31'd0, busy_o}, 32'd0);

    // single 16-bit last frame (upper junk ignored), then a 32-bit frame
    send_frame(2'd1, 32'h1234BEEF, 1'b1);
    chk("t3_beef_data", word_data_o, 32'h0000BEEF);
    chk("t3_beef_bcnt", {29'd0, word_bcnt_o}, 32'd2);
    send_frame(2'd3, 32'hCAFEF00D, 1'b0);
    chk("t3_cafe_data", word_data_o, 32'hCAFEF00D);
    chk("t3_cafe_bcnt", {29'd0, word_bcnt_o}, 32'd4);
    idle(2);

    // backpressure: held word stays stable, frame waits, accepted on release
    word_ready_i = 1'b0;
    send_frame(2'd0, 32'h01, 1'b0);
    send_frame(2'd0, 32'h02, 1'b0);
    send_frame(2'd0, 32'h03, 1'b0);
    send_frame(2'd0, 32'h04, 1'b0);
    rdtb_i = 2'd0;
    frm_data_i = 32'h77;
    frm_last_i = 1'b1;
    frm_valid_i = 1'b1;
    for (int c = 0; c < 5; c++) begin
      idle(1);
      chk("t4_hold_data", word_data_o, 32'h04030201);
      chk("t4_hold_bcnt", {29'd0, word_bcnt_o}, 32'd4);
      chk("t4_hold_ready", {31'd0, frm_ready_o}, 32'd0);
    end
    word_ready_i = 1'b1;
    #1;
    chk("t4_release_ready", {31'd0, frm_ready_o}, 32'd1);
    @(posedge clk_i);
    #1;
    frm_valid_i = 1'b0;
    frm_last_i = 1'b0;
    chk("t4_new_data", word_data_o, 32'h00000077);
    chk("t4_new_bcnt", {29'd0, word_bcnt_o}, 32'd1);
    idle(1);

    // en_i low for one cycle discards staged bytes
    send_frame(2'd0, 32'hA1, 1'b0);
    send_frame(2'd0, 32'hA2, 1'b0);
    send_frame(2'd0, 32'hA3, 1'b0);
    chk("t5_fill3", {30'd0, fill_o}, 32'd3);
    en_i = 1'b0;
    idle(1);
    en_i = 1'b1;
    chk("t5_fill0", {30'd0, fill_o}, 32'd0);
    chk("t5_valid0", {31'd0, word_valid_o}, 32'd0);
    send_frame(2'd0, 32'h5A, 1'b1);
    chk("t5_data", word_data_o, 32'h0000005A);
    chk("t5_bcnt", {29'd0, word_bcnt_o}, 32'd1);
    idle(2);

    // asynchronous reset while in FLUSH with a word pending
    send_frame(2'd2, 32'h00030201, 1'b0);
    send_frame(2'd2, 32'h00060504, 1'b1);
    word_ready_i = 1'b0;
    #1;
    chk("t6_pre_valid", {31'd0, word_valid_o}, 32'd1);
    chk("t6_pre_busy", {31'd0, busy_o}, 32'd1);
    rst_i = 1'b1;
    #1;
    chk("t6_async_valid", {31'd0, word_valid_o}, 32'd0);
    chk("t6_async_data", word_data_o, 32'd0);
    chk("t6_async_bcnt", {29'd0, word_bcnt_o}, 32'd0);
    chk("t6_async_fill", {30'd0, fill_o}, 32'd0);
    chk("t6_async_busy", {31'd0, busy_o}, 32'd0);
    chk("t6_async_ready", {31'd0, frm_ready_o}, 32'd0);
    idle(2);
    rst_i = 1'b0;
    word_ready_i = 1'b1;
    send_frame(2'd0, 32'hEE, 1'b1);
    chk("t6_resume_data", word_data_o, 32'h000000EE);
    chk("t6_resume_bcnt", {29'd0, word_bcnt_o}, 32'd1);
    idle(2);

    // randomized frames with random backpressure, checked by the model
    rdy_rand = 1'b1;
    for (int f = 0; f < 400 && timeouts < 3; f++) begin
      if ($urandom_range(0, 49) == 0) begin
        en_i = 1'b0;
        idle(1);
        en_i = 1'b1;
      end
      idle($urandom_range(0, 2));
      send_frame(2'($urandom_range(0, 3)), $urandom(), ($urandom_range(0, 3) == 0));
    end
    rdy_rand = 1'b0;
    idle(1);
    word_ready_i = 1'b1;
    send_frame(2'd0, 32'h99, 1'b1);
    idle(4);
    chk("final_idle_busy", {31'd0, busy_o}, 32'd0);

    sim_done = 1'b1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global time bound
  initial begin
    #600000;
    failures++;
    $display("FAIL global_timeout: got running expected finished at %0t", $time);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
